br_unit_mc: RTL

- Registered, handshaked branch resolution unit for the multi-cycle core. Generalises the combinational branch comparator: resolves all nine one-hot branch types (BEQ, BNE, BLT, BGE, BLTU, BGEU, B, BL, JIRL).
- Parametrised in datapath width, link offset and target alignment.
- Adds link-register write-back, misaligned-target detection and invalid-type detection.
- Sits between the decode/register-read stage and the PC-update/write-back stage, using a valid/ready handshake on both sides.

---
 rtl/br_unit_mc.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/br_unit_mc.sv
// br_unit_mc: registered, valid/ready handshaked branch resolution unit (IDLE -> EVAL -> HOLD).
// Define BR_UNIT_MC_PERF_CNT_EN to add the br_cnt/taken_cnt performance counters.
module br_unit_mc #(
  parameter int XLEN        = 32,
  parameter int LINK_OFFSET = 4,
  parameter int ALIGN_BITS  = 2
`ifdef BR_UNIT_MC_PERF_CNT_EN
  ,parameter int CNT_W      = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8:0]      br_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            jump_en,
  output logic [XLEN-1:0] jump_target,
  output logic            link_wen,
  output logic [XLEN-1:0] link_data,
  output logic            target_misalign,
  output logic            type_err
`ifdef BR_UNIT_MC_PERF_CNT_EN
  ,output logic [CNT_W-1:0] br_cnt
  ,output logic [CNT_W-1:0] taken_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_HOLD} state_t;

  state_t r_state;
  state_t w_next;

  logic [8:0]      r_type;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_imm;

  logic            r_jump_en, r_link_wen, r_misalign, r_type_err;
  logic [XLEN-1:0] r_target, r_link_data;

  logic            w_onehot, w_cond, w_taken, w_is_link, w_misalign;
  logic [XLEN-1:0] w_target, w_align_mask;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_EVAL;
      S_EVAL:  w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake flags are gated by rst so nothing is offered or accepted while in reset.
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_HOLD) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_type <= '0;
      r_pc   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_imm  <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_type <= br_type;
      r_pc   <= pc;
      r_a    <= rf_rdata1;
      r_b    <= rf_rdata2;
      r_imm  <= imm;
    end
  end

  assign w_onehot     = (r_type != 9'd0) && ((r_type & (r_type - 9'd1)) == 9'd0);
  assign w_is_link    = w_onehot && (r_type[7] || r_type[8]);
  assign w_align_mask = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  assign w_target     = (r_type[8] ? r_a : r_pc) + r_imm;

  always_comb begin
    w_cond = 1'b0;
    case (r_type)
      9'b000000001: w_cond = (r_a == r_b);
      9'b000000010: w_cond = (r_a != r_b);
      9'b000000100: w_cond = ($signed(r_a) <  $signed(r_b));
      9'b000001000: w_cond = ($signed(r_a) >= $signed(r_b));
      9'b000010000: w_cond = (r_a <  r_b);
      9'b000100000: w_cond = (r_a >= r_b);
      9'b001000000,
      9'b010000000,
      9'b100000000: w_cond = 1'b1;
      default:      w_cond = 1'b0;
    endcase
  end

  assign w_taken    = w_cond;
  assign w_misalign = w_taken && ((w_target & w_align_mask) != '0);

  // Results are computed only in EVAL and then held, so HOLD outputs stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_jump_en   <= 1'b0;
      r_target    <= '0;
      r_link_wen  <= 1'b0;
      r_link_data <= '0;
      r_misalign  <= 1'b0;
      r_type_err  <= 1'b0;
    end else if (r_state == S_EVAL) begin
      r_jump_en   <= w_taken && !w_misalign;
      r_target    <= (w_taken && !w_misalign) ? w_target : '0;
      r_link_wen  <= w_is_link && !w_misalign;
      r_link_data <= (w_is_link && !w_misalign) ? (r_pc + XLEN'(LINK_OFFSET)) : '0;
      r_misalign  <= w_misalign;
      r_type_err  <= !w_onehot;
    end
  end

  assign jump_en         = r_jump_en;
  assign jump_target     = r_target;
  assign link_wen        = r_link_wen;
  assign link_data       = r_link_data;
  assign target_misalign = r_misalign;
  assign type_err        = r_type_err;

`ifdef BR_UNIT_MC_PERF_CNT_EN
  logic [CNT_W-1:0] r_br_cnt, r_taken_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (r_jump_en) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign br_cnt    = r_br_cnt;
  assign taken_cnt = r_taken_cnt;
`endif

endmodule
